// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Memory-side responder for the instruction and data cache ports. Requests
// from the two ports are arbitrated round-robin, then serviced against an
// internal word-addressed RAM after a fixed LAT-cycle access delay.
// Completion is a single-cycle low pulse on iwait/dwait, with iload/dload
// carrying the read word during that pulse.
module cache_mem_responder #(
    parameter int LAT     = 2,
    parameter int DEPTH_W = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        READY
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    // The counter must hold LAT itself; LAT=0 still needs one bit.
    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    state_t             state;
    state_t             state_nx;
    port_t              grant;
    port_t              grant_nx;
    port_t              last;
    logic [CNT_W-1:0]   cnt;

    // Transaction captured at grant time; the abort check compares against it.
    logic               op_wr;
    logic [31:0]        op_addr;
    logic [31:0]        op_data;
    logic [DEPTH_W-1:0] op_idx;
    logic [31:0]        rdata;

    logic [31:0]        mem [0:(1<<DEPTH_W)-1];

    logic               i_req;
    logic               d_req;
    logic               do_grant;
    logic               do_op;
    logic               abort;

    assign i_req  = iREN;
    assign d_req  = dREN | dWEN;
    assign op_idx = op_addr[DEPTH_W+1:2];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: arbitration in IDLE, countdown/abort in ACCESS.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        do_grant = 1'b0;
        do_op    = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    do_grant = 1'b1;
                    state_nx = ACCESS;
                    if (i_req && d_req) begin
                        grant_nx = (last == PORT_I) ? PORT_D : PORT_I;
                    end else if (d_req) begin
                        grant_nx = PORT_D;
                    end else begin
                        grant_nx = PORT_I;
                    end
                end
            end
            ACCESS: begin
                if (grant == PORT_I) begin
                    abort = !iREN || (iaddr != op_addr);
                end else begin
                    abort = !d_req || (daddr != op_addr) || (dWEN != op_wr);
                end
                if (abort) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    do_op    = 1'b1;
                    state_nx = READY;
                end
            end
            READY: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Transaction capture, latency counter, arbitration history and read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant   <= PORT_I;
            last    <= PORT_I;
            cnt     <= '0;
            op_wr   <= 1'b0;
            op_addr <= '0;
            op_data <= '0;
            rdata   <= '0;
        end else begin
            if (do_grant) begin
                grant   <= grant_nx;
                last    <= grant_nx;
                op_wr   <= (grant_nx == PORT_D) && dWEN;
                op_addr <= (grant_nx == PORT_D) ? daddr : iaddr;
                op_data <= dstore;
                cnt     <= CNT_W'(LAT);
            end else if (state == ACCESS && !abort && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_op && !op_wr) begin
                rdata <= mem[op_idx];
            end
        end
    end

    // RAM write port; contents are never reset, and reset blocks a pending write.
    always_ff @(posedge CLK) begin
        if (!RST && do_op && op_wr) begin
            mem[op_idx] <= op_data;
        end
    end

    assign iwait = !(state == READY && grant == PORT_I);
    assign dwait = !(state == READY && grant == PORT_D);
    assign iload = rdata;
    assign dload = rdata;

endmodule
